// File: rtl/seg_pkg.sv
// Shared types, constants and the segment decoder for the scanned seven-segment display.
package seg_pkg;

    typedef enum logic [1:0] {
        MODE_HEX   = 2'b00,
        MODE_DEC   = 2'b01,
        MODE_BIN   = 2'b10,
        MODE_BLANK = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StCommit
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Digit codes 0..15 are hex glyphs; two extra codes for blank and dash.
    localparam logic [4:0] CODE_BLANK = 5'd16;
    localparam logic [4:0] CODE_DASH  = 5'd17;

    // Active-low segments, bit0=a .. bit6=g.
    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        logic [6:0] seg;
        case (code)
            5'd0:    seg = 7'h40;
            5'd1:    seg = 7'h79;
            5'd2:    seg = 7'h24;
            5'd3:    seg = 7'h30;
            5'd4:    seg = 7'h19;
            5'd5:    seg = 7'h12;
            5'd6:    seg = 7'h02;
            5'd7:    seg = 7'h78;
            5'd8:    seg = 7'h00;
            5'd9:    seg = 7'h10;
            5'd10:   seg = 7'h08;
            5'd11:   seg = 7'h03;
            5'd12:   seg = 7'h46;
            5'd13:   seg = 7'h21;
            5'd14:   seg = 7'h06;
            5'd15:   seg = 7'h0E;
            CODE_DASH: seg = SEG_DASH;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_scan_display_bin2bcd_seq.sv
// Sequential double-dabble: first shift on start, remaining WIDTH-1 shift/add-3 steps
// follow one per cycle; done pulses for one cycle once bcd holds the final result.
module bin2bcd_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [WIDTH-1:0]               bin,
    output logic                           done,
    output logic [4*((WIDTH+2)/3)-1:0]     bcd
);

    localparam int unsigned BcdDigits = (WIDTH + 2) / 3;
    localparam int unsigned BcdW      = 4 * BcdDigits;
    localparam int unsigned CntW      = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [BcdW-1:0]  bcd_q, bcd_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [BcdW-1:0]  adj;

    always_comb begin
        adj = bcd_q;
        for (int unsigned i = 0; i < BcdDigits; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end

        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (start) begin
            // The first step needs no add-3 since the BCD accumulator starts at zero.
            bcd_d = BcdW'(bin[WIDTH-1]);
            bin_d = {bin[WIDTH-2:0], 1'b0};
            cnt_d = CntW'(WIDTH - 1);
        end else if (cnt_q != '0) begin
            bcd_d  = BcdW'({adj, bin_q[WIDTH-1]});
            bin_d  = {bin_q[WIDTH-2:0], 1'b0};
            cnt_d  = cnt_q - CntW'(1);
            done_d = (cnt_q == CntW'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed seven-segment controller: hex/decimal/binary/blank rendering of a loaded
// value over DIGITS scanned digits. Define SEG_LZ_BLANK_EN to blank hex/decimal leading zeros.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  value,
    input  logic [1:0]        mode,
    input  logic              load,
    output logic              busy,
    output logic              ovf,
    output logic [6:0]        seg_n,
    output logic [DIGITS-1:0] an_n
);

    localparam int unsigned BcdW  = 4 * ((WIDTH + 2) / 3);
    localparam int unsigned ScanW = $clog2(SCAN_DIV);
    localparam int unsigned IdxW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] value_q, value_d;
    mode_e            mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;
    logic [4:0]       digit_q [DIGITS];
    logic [4:0]       digit_d [DIGITS];

    logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [6:0]        seg_n_q, seg_n_d;
    logic [DIGITS-1:0] an_n_q, an_n_d;

    logic             bcd_start;
    logic             bcd_done;
    logic [BcdW-1:0]  bcd;
    logic [4:0]       new_code [DIGITS];
    logic             new_ovf;

    bin2bcd_seq #(
        .WIDTH (WIDTH)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (bcd_start),
        .bin   (value),
        .done  (bcd_done),
        .bcd   (bcd)
    );

    // Digit codes and overflow flag that COMMIT will write.
    always_comb begin
        new_ovf = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            new_code[k] = CODE_BLANK;
        end
        unique case (mode_q)
            MODE_HEX: begin
                for (int unsigned k = 0; k < DIGITS; k++) begin
                    new_code[k] = {1'b0, 4'(value_q >> (4 * k))};
                end
                new_ovf = (32'(value_q) >> (4 * DIGITS)) != '0;
            end
            MODE_DEC: begin
                for (int unsigned k = 0; k < DIGITS; k++) begin
                    new_code[k] = {1'b0, 4'(bcd >> (4 * k))};
                end
                new_ovf = (32'(bcd) >> (4 * DIGITS)) != '0;
            end
            MODE_BIN: begin
                for (int unsigned k = 0; k < DIGITS; k++) begin
                    new_code[k] = {4'b0, 1'(value_q >> k)};
                end
                new_ovf = (32'(value_q) >> DIGITS) != '0;
            end
            MODE_BLANK: ;
        endcase
`ifdef SEG_LZ_BLANK_EN
        if (mode_q == MODE_HEX || mode_q == MODE_DEC) begin
            logic lead;
            lead = 1'b1;
            // Digit 0 is never blanked so a zero value still reads "0".
            for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
                if (lead && new_code[k] == 5'd0) begin
                    new_code[k] = CODE_BLANK;
                end else begin
                    lead = 1'b0;
                end
            end
        end
`endif
        if (new_ovf) begin
            for (int unsigned k = 0; k < DIGITS; k++) begin
                new_code[k] = CODE_DASH;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        value_d   = value_q;
        mode_d    = mode_q;
        busy_d    = busy_q;
        ovf_d     = ovf_q;
        digit_d   = digit_q;
        bcd_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    value_d   = value;
                    mode_d    = mode_e'(mode);
                    busy_d    = 1'b1;
                    state_d   = StConv;
                    bcd_start = (mode_e'(mode) == MODE_DEC);
                end
            end
            StConv: begin
                if (mode_q != MODE_DEC || bcd_done) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                digit_d = new_code;
                ovf_d   = new_ovf;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            value_q <= '0;
            mode_q  <= MODE_BLANK;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            for (int unsigned k = 0; k < DIGITS; k++) begin
                digit_q[k] <= CODE_BLANK;
            end
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            digit_q <= digit_d;
        end
    end

    // Free-running scan, independent of the conversion FSM.
    always_comb begin
        scan_cnt_d = scan_cnt_q + ScanW'(1);
        idx_d      = idx_q;
        if (scan_cnt_q == ScanW'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            idx_d      = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
        end
        seg_n_d = seg_decode(digit_q[idx_q]);
        an_n_d  = ~(DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            idx_q      <= '0;
            seg_n_q    <= SEG_BLANK;
            an_n_q     <= ~DIGITS'(1);
        end else begin
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            seg_n_q    <= seg_n_d;
            an_n_q     <= an_n_d;
        end
    end

    assign busy  = busy_q;
    assign ovf   = ovf_q;
    assign seg_n = seg_n_q;
    assign an_n  = an_n_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: 4-digit and 2-digit instances, arithmetic model.
module tb_seg_scan_display;

    localparam int W    = 8;
    localparam int SCAN = 4;
    // Lit-segment masks (gfedcba, active high) for glyphs 0..F.
    localparam logic [6:0] LIT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        int          busy_len;
        bit          ovf;
        logic [27:0] seg;
        int          nd;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] value;
    logic [1:0]   mode;
    logic         load;
    logic         sel;
    logic         load4, load2;
    logic         busy4, busy2, ovf4, ovf2;
    logic [6:0]   seg4, seg2;
    logic [3:0]   an4;
    logic [1:0]   an2;
    logic         busy_s, ovf_s;
    logic [6:0]   seg_s;
    logic [3:0]   an_s;

    int   compared   = 0;
    int   mismatched = 0;
    int   mon_done   = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    assign load4  = load & ~sel;
    assign load2  = load & sel;
    assign busy_s = sel ? busy2 : busy4;
    assign ovf_s  = sel ? ovf2 : ovf4;
    assign seg_s  = sel ? seg2 : seg4;
    assign an_s   = sel ? {2'b11, an2} : an4;

    seg_scan_display #(.WIDTH(W), .DIGITS(4), .SCAN_DIV(SCAN)) dut4 (
        .clk(clk), .rst_n(rst_n), .value(value), .mode(mode), .load(load4),
        .busy(busy4), .ovf(ovf4), .seg_n(seg4), .an_n(an4)
    );

    seg_scan_display #(.WIDTH(W), .DIGITS(2), .SCAN_DIV(SCAN)) dut2 (
        .clk(clk), .rst_n(rst_n), .value(value), .mode(mode), .load(load2),
        .busy(busy2), .ovf(ovf2), .seg_n(seg2), .an_n(an2)
    );

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic int ipow(input int b, input int e);
        int r = 1;
        repeat (e) r *= b;
        return r;
    endfunction

    function automatic exp_t model(input int v, input int m, input int nd);
        exp_t e;
        int   base;
        logic [6:0] s;
        e.nd       = nd;
        e.busy_len = (m == 1) ? W + 1 : 2;
        e.seg      = {4{7'h7F}};
        e.ovf      = 1'b0;
        if (m != 3) begin
            base  = (m == 0) ? 16 : (m == 1) ? 10 : 2;
            e.ovf = (v >= ipow(base, nd));
            for (int k = 0; k < nd; k++) begin
                s = ~LIT[(v / ipow(base, k)) % base];
`ifdef SEG_LZ_BLANK_EN
                if (m != 2 && k > 0 && v < ipow(base, k)) s = 7'h7F;
`endif
                if (e.ovf) s = 7'h3F;
                e.seg[7*k +: 7] = s;
            end
        end
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input int v, input int m);
        value = W'(v);
        mode  = 2'(m);
        load  = 1'b1;
        tick(1);
        load  = 1'b0;
    endtask

    // Issue a load; optionally fire an extra load mid-conversion that must be ignored.
    task automatic issue(input int v, input int m, input bit extra);
        int target;
        bit ok = 1'b0;
        target = mon_done + 1;
        q.push_back(model(v, m, sel ? 2 : 4));
        pulse_load(v, m);
        if (extra) begin
            tick(3);
            pulse_load((v + 77) % 256, 0);
        end
        for (int c = 0; c < 300; c++) begin
            if (mon_done >= target) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        if (!ok) chk("result_timeout", 0, 1);
    endtask

    initial begin : monitor
        int   blen;
        exp_t e;
        int   got [4];
        bit   bad;
        int   zeros;
        int   j;
        blen = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                blen = 0;
            end else if (busy_s) begin
                blen++;
            end else if (blen > 0) begin
                if (q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_commit: got a result, required none");
                end else begin
                    e = q.pop_front();
                    chk("busy_len", blen, e.busy_len);
                    chk("ovf", int'(ovf_s), int'(e.ovf));
                    got = '{default: -1};
                    bad = 1'b0;
                    repeat (6 * SCAN + 2) begin
                        @(negedge clk);
                        zeros = 0;
                        j     = 0;
                        for (int b = 0; b < 4; b++) begin
                            if (!an_s[b]) begin
                                zeros++;
                                j = b;
                            end
                        end
                        if (zeros != 1) bad = 1'b1;
                        else if (j < e.nd) got[j] = int'(seg_s);
                    end
                    chk("an_onehot", int'(bad), 0);
                    for (int k = 0; k < e.nd; k++) begin
                        chk($sformatf("seg_digit%0d", k), got[k], int'(e.seg[7*k +: 7]));
                    end
                end
                blen = 0;
                mon_done++;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [3:0] an_hist [48];
        int         run, nchg, zi;
        logic [3:0] exp_an;

        rst_n = 1'b0;
        load  = 1'b0;
        sel   = 1'b0;
        value = '0;
        mode  = '0;
        tick(3);
        rst_n = 1'b1;
        chk("rst_seg", int'(seg4), 'h7F);
        chk("rst_an", int'(an4), 'b1110);
        chk("rst_an2", int'(an2), 'b10);
        chk("rst_busy", int'(busy4), 0);
        chk("rst_ovf", int'(ovf4), 0);

        // Scan order and dwell time.
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            an_hist[i] = an4;
        end
        run  = 1;
        nchg = 0;
        for (int i = 1; i < 48; i++) begin
            if (an_hist[i] != an_hist[i-1]) begin
                zi = 0;
                for (int b = 0; b < 4; b++) if (!an_hist[i-1][b]) zi = b;
                exp_an = ~(4'b0001 << ((zi + 1) % 4));
                chk("scan_next", int'(an_hist[i]), int'(exp_an));
                if (nchg > 0) chk("scan_dwell", run, SCAN);
                nchg++;
                run = 1;
            end else begin
                run++;
            end
        end
        chk("scan_changes", int'(nchg >= 10), 1);
        tick(1);

        issue('hA5, 0, 1'b0);
        issue(255, 1, 1'b1);
        issue(0, 0, 1'b0);
        issue('h5A, 2, 1'b0);

        sel = 1'b1;
        issue(200, 1, 1'b0);
        issue('h3C, 0, 1'b0);
        sel = 1'b0;

        // Reset three cycles into a decimal conversion.
        pulse_load(200, 1);
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy4), 0);
        chk("mid_rst_ovf", int'(ovf4), 0);
        chk("mid_rst_seg", int'(seg4), 'h7F);
        chk("mid_rst_an", int'(an4), 'b1110);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        issue(42, 1, 1'b0);

        for (int n = 0; n < 24; n++) begin
            sel = 1'($urandom_range(0, 1));
            issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), 1'b0);
        end

        chk("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Parametrised, time-multiplexed seven-segment display controller; the multi-digit successor to the board's single-digit combinational hex/decimal display path. Captures a WIDTH-bit value on a load strobe and renders it as hex, decimal or binary over DIGITS common-anode digits. Decimal conversion uses sequential double-dabble. Drives one shared active-low segment bus plus per-digit anode enables.

## Interface
- WIDTH, 8: width of `value`; legal range 4..16.
- DIGITS, 4: number of scanned digits; legal range 1..8.
- SCAN_DIV, 50000: clock cycles each digit stays enabled; minimum 2.
- clk  in  1  single system clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- value  in  WIDTH  unsigned value; sampled on an accepted load.
- mode  in  2  sampled on load: 00 hex, 01 decimal, 10 binary, 11 blank.
- load  in  1  one-cycle capture request; accepted only when busy=0.
- busy  out  1  conversion in progress.
- ovf  out  1  last loaded value did not fit in DIGITS digits.
- seg_n  out  7  active-low segments; bit0=a … bit6=g; registered.
- an_n  out  DIGITS  active-low digit enables; exactly one bit low; registered.

## Operation
- FSM states: IDLE, CONV, COMMIT.
- IDLE + load → CONV. Latch `value` and `mode`.
- CONV duration:
  - Hex, binary, blank: 1 cycle.
  - Decimal: WIDTH cycles, one shift/add-3 step per cycle.
- CONV → COMMIT. COMMIT writes the DIGITS display-digit registers and `ovf` atomically, then returns to IDLE.
- `load` while busy=1 is ignored; no queuing.
- Digit 0 is the least significant digit.
- Hex mode: digit k = nibble k.
  - ovf when value ≥ 16^DIGITS.
- Decimal mode: BCD width is ceil(WIDTH/3) digits.
  - ovf when any BCD digit at index ≥ DIGITS is nonzero.
- Binary mode: digit k shows 0 or 1 from value bit k.
  - ovf when any value bit at index ≥ DIGITS is set.
- Blank mode: all digits blank; ovf=0.
- On ovf, every digit shows a dash (only g lit, seg_n=7'h3F).
- The display keeps its previous contents during CONV; no partial update is ever visible.
- Scanning runs continuously, independent of the FSM:
  - Counter runs 0..SCAN_DIV-1.
  - On wrap, the digit index advances modulo DIGITS.
- seg_n and an_n are registered from the digit index and the digit register at that index.
- Reset mid-conversion aborts the conversion and clears all state.

## Timing
- Reset values:
  - busy=0, ovf=0, FSM=IDLE.
  - Digit registers = blank, so seg_n=7'h7F.
  - Scan counter=0, digit index=0.
  - an_n = all ones except bit0 = 0.
- Load latency, with load sampled high at edge t:
  - busy=1 from t+1.
  - Hex/binary/blank: busy falls at t+3; new digits and ovf are visible at t+3.
  - Decimal: busy is high for WIDTH+1 cycles.
- Display output latency: seg_n and an_n reflect a committed digit register change one cycle after COMMIT, at the currently scanned index.
- Index change: an_n and seg_n update together, one cycle after the scan counter wraps.

## Configuration
- SEG_LZ_BLANK_EN:
  - Defined: in hex and decimal modes, zero digits above the most significant nonzero digit are blanked. Digit 0 is always shown, so value 0 displays "0".
  - Undefined: all leading zeros are displayed.
- Binary, blank and ovf rendering are unaffected by the macro.

## Structure
- Package seg_pkg holds:
  - Mode enum (MODE_HEX, MODE_DEC, MODE_BIN, MODE_BLANK).
  - FSM state enum.
  - Constants SEG_BLANK=7'h7F and SEG_DASH=7'h3F.
  - Function digit-code → seg_n, covering 0–F plus blank/dash codes.
- One sub-module, bin2bcd_seq, performs the sequential double-dabble.
  - Ports: start, bin, done, bcd.
  - Parametrised by WIDTH.

## Test plan
Bench parameters: WIDTH=8, DIGITS=4, SCAN_DIV=4.
- Reset: hold rst_n low, then release → seg_n=7'h7F, an_n=4'b1110, busy=0, ovf=0.
- Scan: after reset, an_n sequence 1110→1101→1011→0111→1110, each held exactly 4 cycles.
- Hex: load 8'hA5, mode 00 → busy high 2 cycles; digits 0,0,A,5; digit 0 shows seg_n=7'h12; ovf=0.
  - With SEG_LZ_BLANK_EN, digits 3 and 2 show 7'h7F.
- Decimal: load 8'd255, mode 01 → busy high exactly 9 cycles; digits 0,2,5,5.
  - Second load during busy is ignored; the result is unchanged.
- Overflow: DIGITS=2, decimal load 8'd200 → ovf=1; both digits show 7'h3F.
  - Then hex load 8'h3C → ovf=0; digits 3 and C.
- Reset mid-conversion: assert rst_n low 3 cycles into a decimal conversion → all outputs return to reset values immediately.
  - After release, a fresh load 8'd42 displays 0,0,4,2.
